// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared state encoding and default parameters for the Z80
//               memory-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int          DEF_ROM_ADDR_BITS = 4;
    localparam int          DEF_ROM_WAIT      = 2;
    localparam int          DEF_RAM_WAIT      = 0;
    localparam logic [7:0]  DEF_CFG_PORT      = 8'hFE;

    // Counter must hold the larger wait count; keep at least one bit.
    function automatic int wait_cnt_width(input int rom_wait, input int ram_wait);
        int max_wait;
        max_wait = (rom_wait > ram_wait) ? rom_wait : ram_wait;
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_port_reg.sv
// ============================================================================
// Module      : cfg_port_reg
// Description : I/O-mapped ROM-enable register, loaded once per I/O cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_port_reg
    import mem_ctrl_pkg::*;
#(
    parameter logic [7:0] CFG_PORT = DEF_CFG_PORT
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic [7:0] port_addr,
    input  logic       n_iorq,
    input  logic       n_wr,
    input  logic       cfg_bit,
    output logic       rom_enabled
);

    logic r_armed;
    logic w_cfg_write;

    assign w_cfg_write = !n_iorq && !n_wr && (port_addr == CFG_PORT);

    // The arm flag blocks repeat loads while the same I/O cycle is held.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rom_enabled <= 1'b1;
            r_armed     <= 1'b1;
        end else if (n_iorq) begin
            r_armed     <= 1'b1;
        end else if (r_armed && w_cfg_write) begin
            rom_enabled <= cfg_bit;
            r_armed     <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_cycle_ctrl.sv
// ============================================================================
// Module      : mem_cycle_ctrl
// Description : Z80 memory-cycle controller: ROM/RAM decode, wait-state
//               insertion and single-cycle memory strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_cycle_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ROM_ADDR_BITS = DEF_ROM_ADDR_BITS,
    parameter int         ROM_WAIT      = DEF_ROM_WAIT,
    parameter int         RAM_WAIT      = DEF_RAM_WAIT,
    parameter logic [7:0] CFG_PORT      = DEF_CFG_PORT
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [15:0] address,
    input  logic        n_mreq,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic [7:0]  data_in,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic        n_wait,
    output logic        rom_enabled
);

    localparam int               CNT_W      = wait_cnt_width(ROM_WAIT, RAM_WAIT);
    localparam logic [CNT_W-1:0] C_ROM_WAIT = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] C_RAM_WAIT = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_is_read;

    logic             w_start;
    logic             w_in_rom;
    logic             w_sel_rom;
    logic [CNT_W-1:0] w_load_cnt;
    logic             w_abort;
    logic             w_unused_data;

    cfg_port_reg #(
        .CFG_PORT    (CFG_PORT)
    ) u_cfg_port_reg (
        .clock       (clock),
        .n_reset     (n_reset),
        .port_addr   (address[7:0]),
        .n_iorq      (n_iorq),
        .n_wr        (n_wr),
        .cfg_bit     (data_in[0]),
        .rom_enabled (rom_enabled)
    );

    assign w_unused_data = ^data_in[7:1];

    // Writes always land in RAM, so ROM-region writes shadow into RAM.
    assign w_start    = !n_mreq && (n_rd ^ n_wr);
    assign w_in_rom   = (address[15:ROM_ADDR_BITS] == '0);
    assign w_sel_rom  = !n_rd && w_in_rom && rom_enabled;
    assign w_load_cnt = w_sel_rom ? C_ROM_WAIT : C_RAM_WAIT;
    assign w_abort    = n_mreq && ((r_state == ST_WAIT) || (r_state == ST_ACCESS));

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_is_read  <= 1'b0;
            rom_cs     <= 1'b0;
            ram_cs     <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            n_wait     <= 1'b1;
        end else if (w_abort) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            rom_cs     <= 1'b0;
            ram_cs     <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            n_wait     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        rom_cs    <= w_sel_rom;
                        ram_cs    <= !w_sel_rom;
                        r_is_read <= !n_rd;
                        if (w_load_cnt != '0) begin
                            r_wait_cnt <= w_load_cnt;
                            n_wait     <= 1'b0;
                            r_state    <= ST_WAIT;
                        end else begin
                            mem_rd_en  <= !n_rd;
                            mem_wr_en  <= !n_wr;
                            r_state    <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    // Strobe is set on the edge that ends the last wait cycle.
                    if (r_wait_cnt <= C_ONE) begin
                        r_wait_cnt <= '0;
                        n_wait     <= 1'b1;
                        mem_rd_en  <= r_is_read;
                        mem_wr_en  <= !r_is_read;
                        r_state    <= ST_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - C_ONE;
                    end
                end
                ST_ACCESS: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (n_mreq) begin
                        rom_cs  <= 1'b0;
                        ram_cs  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_cycle_ctrl.sv
// ============================================================================
// Module      : tb_mem_cycle_ctrl
// Description : Scoreboard bench for mem_cycle_ctrl with randomized Z80 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_cycle_ctrl;

    localparam int         ROM_WAIT = 2;
    localparam int         RAM_WAIT = 0;
    localparam logic [7:0] CFG_PORT = 8'hFE;

    logic        clock   = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] address = '0;
    logic        n_mreq  = 1'b1;
    logic        n_iorq  = 1'b1;
    logic        n_rd    = 1'b1;
    logic        n_wr    = 1'b1;
    logic [7:0]  data_in = '0;
    logic        rom_cs, ram_cs, mem_rd_en, mem_wr_en, n_wait, rom_enabled;

    typedef struct {
        logic rom;
        logic rd;
        int   waits;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   run         = 0;
    logic model_rom_en = 1'b1;

    mem_cycle_ctrl #(
        .ROM_ADDR_BITS (4),
        .ROM_WAIT      (ROM_WAIT),
        .RAM_WAIT      (RAM_WAIT),
        .CFG_PORT      (CFG_PORT)
    ) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .address     (address),
        .n_mreq      (n_mreq),
        .n_iorq      (n_iorq),
        .n_rd        (n_rd),
        .n_wr        (n_wr),
        .data_in     (data_in),
        .rom_cs      (rom_cs),
        .ram_cs      (ram_cs),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .n_wait      (n_wait),
        .rom_enabled (rom_enabled)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every strobe pops the oldest expected access.
    always @(negedge clock) begin
        if (n_reset) begin
            chk("cs_exclusive", 32'(rom_cs & ram_cs), 32'd0);
            if (mem_rd_en || mem_wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_target", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en}),
                        32'({mon_e.rom, !mon_e.rom, mon_e.rd, !mon_e.rd}));
                    chk("wait_cycles", 32'(run), 32'(mon_e.waits));
                end
                run = 0;
            end else if (!n_wait) begin
                run++;
            end else begin
                run = 0;
            end
        end else begin
            run = 0;
        end
    end

    task automatic mem_cycle(input logic [15:0] a, input logic rd, input logic abort_req);
        exp_t e;
        logic tgt_rom;
        logic abort;
        int   w;
        bit   got;
        int   h;
        tgt_rom = rd && (a < 16'd16) && model_rom_en;
        w       = tgt_rom ? ROM_WAIT : RAM_WAIT;
        abort   = abort_req && (w > 0);
        @(negedge clock);
        address = a;
        n_mreq  = 1'b0;
        n_rd    = !rd;
        n_wr    = rd;
        if (!abort) begin
            e.rom = tgt_rom; e.rd = rd; e.waits = w;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        chk("start_cs", 32'({rom_cs, ram_cs, n_wait}), 32'({tgt_rom, !tgt_rom, (w == 0)}));
        if (abort) begin
            @(negedge clock);
            n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
            @(posedge clock); #1;
            chk("abort_idle", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en, n_wait}), 32'h01);
            return;
        end
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clock);
            got = mem_rd_en || mem_wr_en;
        end
        if (!got) chk("pulse_timeout", 32'd0, 32'd1);
        @(negedge clock);
        chk("hold", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en}), 32'({tgt_rom, !tgt_rom, 2'b00}));
        h = $urandom_range(0, 2);
        for (int k = 0; k < h; k++) begin
            @(negedge clock);
            chk("hold_cs", 32'({rom_cs, ram_cs}), 32'({tgt_rom, !tgt_rom}));
        end
        n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        @(posedge clock); #1;
        chk("release_cs", 32'({rom_cs, ram_cs}), 32'd0);
    endtask

    // Data is flipped mid-cycle: only the first edge of the cycle may load.
    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(negedge clock);
        address = {8'($urandom), port};
        n_iorq  = 1'b0;
        n_wr    = 1'b0;
        data_in = d;
        @(negedge clock);
        data_in = ~d;
        @(negedge clock);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        if (port == CFG_PORT) model_rom_en = d[0];
        @(posedge clock); #1;
        chk("rom_enabled", 32'(rom_enabled), 32'(model_rom_en));
    endtask

    task automatic bad_start(input logic both_low);
        @(negedge clock);
        address = 16'h0005;
        n_mreq  = 1'b0;
        n_rd    = !both_low;
        n_wr    = !both_low;
        repeat (2) begin
            @(posedge clock); #1;
            chk("no_start", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en, n_wait}), 32'h01);
        end
        @(negedge clock);
        n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   op;
        logic rd;
        logic [15:0] a;
        #12;
        chk("reset_state", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en, n_wait, rom_enabled}), 32'h03);
        @(negedge clock);
        n_reset = 1'b1;

        mem_cycle(16'h0005, 1'b1, 1'b0);
        mem_cycle(16'h8000, 1'b0, 1'b0);
        mem_cycle(16'h0003, 1'b0, 1'b0);
        mem_cycle(16'h0005, 1'b1, 1'b1);
        io_write(8'hFE, 8'h00);
        mem_cycle(16'h0005, 1'b1, 1'b0);
        io_write(8'h12, 8'h01);
        io_write(8'hFE, 8'h01);
        bad_start(1'b1);
        bad_start(1'b0);

        // Asynchronous reset in the middle of a ROM wait sequence.
        @(negedge clock);
        address = 16'h0005; n_mreq = 1'b0; n_rd = 1'b0; n_wr = 1'b1;
        @(posedge clock); #2;
        n_reset = 1'b0;
        #1;
        chk("async_reset", 32'({rom_cs, ram_cs, mem_rd_en, mem_wr_en, n_wait, rom_enabled}), 32'h03);
        n_mreq = 1'b1; n_rd = 1'b1;
        model_rom_en = 1'b1;
        #1 n_reset = 1'b1;
        mem_cycle(16'h0005, 1'b1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 6) begin
                rd = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
                mem_cycle(a, rd, ($urandom_range(0, 4) == 0));
            end else if (op <= 8) begin
                io_write(($urandom_range(0, 1) == 0) ? CFG_PORT : 8'($urandom), 8'($urandom));
            end else begin
                bad_start(1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_cycle_ctrl.md
MEM_CYCLE_CTRL -- requirements
Module: mem_cycle_ctrl

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 4: ROM region is address[15:ROM_ADDR_BITS] == 0, i.e. 16 bytes at h0000.
REQ-002 Parameter ROM_WAIT, default 2: wait states inserted on ROM reads.
REQ-003 Parameter RAM_WAIT, default 0: wait states inserted on RAM reads and writes.
REQ-004 Parameter CFG_PORT, default 8'hFE: I/O port address (address[7:0]) of the ROM-enable register.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port list (name  direction  width  meaning):
- clock  in  1  system clock; all Z80 strobes are synchronous to it.
- n_reset  in  1  asynchronous active-low reset.
- address  in  16  Z80 A0-A15.
- n_mreq  in  1  Z80 memory request, active low.
- n_iorq  in  1  Z80 I/O request, active low.
- n_rd  in  1  Z80 read strobe, active low.
- n_wr  in  1  Z80 write strobe, active low.
- data_in  in  8  Z80 data bus, used only for config writes.
- rom_cs  out  1  ROM chip select, active high.
- ram_cs  out  1  RAM chip select, active high.
- mem_rd_en  out  1  one-cycle read-strobe pulse to the selected memory.
- mem_wr_en  out  1  one-cycle write-strobe pulse to the selected memory.
- n_wait  out  1  Z80 WAIT, active low.
- rom_enabled  out  1  current ROM-enable register value.

Function
REQ-007 FSM states SHALL be IDLE, WAIT, ACCESS and HOLD.
REQ-008 In IDLE, a clock edge sampling n_mreq=0 with exactly one of n_rd or n_wr low SHALL start a cycle; the address is decoded at that edge.
REQ-009 Target select: a read from the ROM region with rom_enabled=1 SHALL select the ROM; every other read and every write SHALL select the RAM.
REQ-010 Writes to the ROM region SHALL go to RAM (shadow write) regardless of rom_enabled.
REQ-011 At the start edge, the selected chip select SHALL be registered high and the wait count N (ROM_WAIT or RAM_WAIT) loaded.
REQ-012 Branch on N: if N>0, next state is WAIT with n_wait=0; if N=0, next state is ACCESS.
REQ-013 WAIT SHALL hold n_wait=0 for exactly N cycles, then move to ACCESS with n_wait=1.
REQ-014 ACCESS SHALL last exactly one cycle:
- mem_rd_en=1 for a read cycle, mem_wr_en=1 for a write cycle;
- next state is HOLD.
REQ-015 HOLD SHALL keep the chip select asserted until n_mreq is sampled high, then return to IDLE and deassert all chip selects at that edge.
REQ-016 n_mreq sampled high in WAIT or ACCESS SHALL abort the cycle:
- go to IDLE and deassert rom_cs, ram_cs, mem_rd_en and mem_wr_en;
- set n_wait=1;
- produce no enable pulse.
REQ-017 n_mreq=0 with n_rd and n_wr both low, or both high, in IDLE SHALL start no cycle.
REQ-018 rom_cs and ram_cs SHALL never be high in the same cycle.
REQ-019 Wait-count width SHALL be wide enough for the maximum of ROM_WAIT and RAM_WAIT, and SHALL never decrement below zero.
REQ-020 Config write: an I/O write (n_iorq=0, n_wr=0, address[7:0]=CFG_PORT) SHALL load data_in[0] into rom_enabled.
REQ-021 The config load SHALL occur once per I/O cycle, on the first edge the condition is sampled true, and is re-armed when n_iorq is sampled high.
REQ-022 A ROM-enable change SHALL affect only memory cycles that start after the change; a cycle in progress keeps its target.

Reset
REQ-023 While n_reset=0, the block SHALL hold:
- state=IDLE;
- rom_cs=0, ram_cs=0, mem_rd_en=0, mem_wr_en=0;
- n_wait=1, rom_enabled=1;
- wait count=0 and the config re-arm flag armed.
REQ-024 Reset asserted mid-cycle SHALL apply all REQ-023 values immediately (asynchronously); the first cycle after release starts from IDLE.

Structure
REQ-025 A shared package mem_ctrl_pkg SHALL hold:
- the state enumeration;
- the default values of ROM_ADDR_BITS, ROM_WAIT, RAM_WAIT and CFG_PORT.
REQ-026 The config register and its re-arm logic SHALL be one sub-module, cfg_port_reg; the FSM and wait counter stay in mem_cycle_ctrl.

Verification
REQ-027 ROM read h0005, rom_enabled=1, ROM_WAIT=2 -> rom_cs high from the start edge; n_wait low exactly 2 cycles; mem_rd_en high 1 cycle; rom_cs low at the edge n_mreq rises.
REQ-028 RAM write h8000, RAM_WAIT=0 -> ram_cs high; mem_wr_en high in the cycle after the start edge; n_wait stays 1.
REQ-029 I/O write port hFE, data h00, then read h0005 -> rom_enabled=0; ram_cs selected; rom_cs stays 0; n_wait never low.
REQ-030 Write h0003 with rom_enabled=1 -> ram_cs and mem_wr_en asserted; rom_cs stays 0.
REQ-031 ROM read with n_mreq released during the 1st wait cycle -> next edge: IDLE, n_wait=1, no mem_rd_en pulse.
REQ-032 n_reset pulsed low during WAIT -> all outputs at reset values without a clock edge; rom_enabled=1; a following ROM read completes normally.
